// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Execute-stage branch resolution and BTB writer. Each accepted branch/jump
// resolution is compared with the prediction made at fetch. A misprediction
// raises a one-cycle registered redirect (and flush) carrying the correct
// fetch PC. Taken branches whose target the BTB did not supply correctly are
// queued in a small FIFO and drained onto the BTB write port, one per cycle.
// Saturating counters track accepted resolutions, mispredicts and updates
// dropped because the queue was full.
//
// Parameters:
//   FIFO_DEPTH  update queue entries (power of two, >= 2)
//   CNT_WIDTH   width of each statistics counter
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   ex_valid                   a control-flow instruction resolves in EX
//   ex_pc, ex_taken, ex_target actual PC / direction / taken target
//   ex_pred_hit                BTB hit at fetch (predicted taken)
//   ex_pred_target             target predicted at fetch
//   update_stall               BTB write port busy this cycle
//   redirect_valid, flush      registered one-cycle mispredict pulse
//   redirect_pc                correct fetch PC (holds after the pulse)
//   update_en                  BTB write strobe
//   pc_update                  BTB write PC (queue head, 0 when empty)
//   target_addr_update         BTB write target (queue head, 0 when empty)
//   cnt_branches               accepted resolutions
//   cnt_mispredicts            mispredictions
//   cnt_dropped                updates lost to a full queue
//
// BTB write handshake: update_en is the valid; !update_stall is the ready.
// update_en is only ever high when the queue is non-empty and the port is
// not stalled, so a cycle with update_en=1 is a completed transfer and the
// head entry is popped on the rising edge that ends that cycle.

module branch_resolve_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic                 ex_pred_hit,
  input  logic [31:0]          ex_pred_target,
  input  logic                 update_stall,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush,
  output logic                 update_en,
  output logic [31:0]          pc_update,
  output logic [31:0]          target_addr_update,
  output logic [CNT_WIDTH-1:0] cnt_branches,
  output logic [CNT_WIDTH-1:0] cnt_mispredicts,
  output logic [CNT_WIDTH-1:0] cnt_dropped
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CQ_W  = PTR_W + 1;
  localparam logic [CQ_W-1:0] DEPTH_C = CQ_W'(FIFO_DEPTH);

  logic             accept;
  logic             target_diff;
  logic             mispredict;
  logic [31:0]      fix_pc;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;

  logic [31:0]      q_pc  [FIFO_DEPTH];
  logic [31:0]      q_tgt [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CQ_W-1:0]  count;

  always_comb begin
    // The cycle right after a redirect carries wrong-path work: ignore it.
    accept      = ex_valid && !redirect_valid;
    target_diff = (ex_pred_target != ex_target);
    mispredict  = accept && ((ex_pred_hit && !ex_taken) ||
                             (!ex_pred_hit && ex_taken) ||
                             (ex_pred_hit && ex_taken && target_diff));
    fix_pc      = ex_taken ? ex_target : (ex_pc + 32'd4);
    // Not-taken never writes: the BTB has no invalidate operation.
    push        = accept && ex_taken && (!ex_pred_hit || target_diff);
    full        = (count == DEPTH_C);
    update_en   = (count != '0) && !update_stall;
    pop         = update_en;
    // When full, a simultaneous pop frees the slot the push needs.
    push_ok     = push && (!full || pop);
    drop        = push && full && !pop;
    pc_update          = (count != '0) ? q_pc[head]  : 32'd0;
    target_addr_update = (count != '0) ? q_tgt[head] : 32'd0;
  end

  assign flush = redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= fix_pc;
    end
  end

  // Queue storage needs no reset: entries are only visible when count != 0.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_pc[tail]  <= ex_pc;
      q_tgt[tail] <= ex_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_branches    <= '0;
      cnt_mispredicts <= '0;
      cnt_dropped     <= '0;
    end else begin
      if (accept && (cnt_branches != '1))
        cnt_branches <= cnt_branches + CNT_WIDTH'(1);
      if (mispredict && (cnt_mispredicts != '1))
        cnt_mispredicts <= cnt_mispredicts + CNT_WIDTH'(1);
      if (drop && (cnt_dropped != '1))
        cnt_dropped <= cnt_dropped + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution block: the writer side of the branch target buffer. It compares each resolved control-flow instruction against the prediction carried down the pipeline and raises a one-cycle registered redirect/flush on misprediction. Required BTB writes are queued in a small FIFO and drained onto the BTB update port, one per cycle. It also keeps saturating branch/mispredict/drop counters.

## Interface
- FIFO_DEPTH, 4, update queue entries; power of two, ≥2
- CNT_WIDTH, 32, width of each statistics counter
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- ex_valid  input  1  a branch/jump resolves in EX this cycle
- ex_pc  input  32  PC of the resolving instruction
- ex_taken  input  1  actual direction (1 = taken; jumps always 1)
- ex_target  input  32  actual taken target
- ex_pred_hit  input  1  BTB hit recorded at fetch (predicted taken)
- ex_pred_target  input  32  target predicted at fetch
- update_stall  input  1  BTB write port unavailable this cycle
- redirect_valid  output  1  registered mispredict pulse
- redirect_pc  output  32  correct fetch PC, valid with redirect_valid
- flush  output  1  equal to redirect_valid; kills IF/ID wrong-path work
- update_en  output  1  BTB write strobe
- pc_update  output  32  BTB write PC (queue head)
- target_addr_update  output  32  BTB write target (queue head)
- cnt_branches  output  CNT_WIDTH  accepted resolutions
- cnt_mispredicts  output  CNT_WIDTH  mispredictions
- cnt_dropped  output  CNT_WIDTH  updates lost to a full queue

## Operation
- Accept = ex_valid && !redirect_valid; a resolution arriving while redirect_valid=1 is wrong-path shadow and is ignored entirely (no redirect, no push, no count).
- Mispredict cases for an accepted resolution:
  - pred_hit=1, taken=0: redirect to ex_pc+4 (32-bit wrap).
  - pred_hit=0, taken=1: redirect to ex_target.
  - pred_hit=1, taken=1, ex_pred_target≠ex_target: redirect to ex_target.
  - otherwise correct, no redirect.
- Push {ex_pc, ex_target} when accepted, taken=1 and (pred_hit=0 or targets differ). Not-taken never pushes (BTB has no invalidate).
- Queue: head/tail pointers wrap modulo FIFO_DEPTH, explicit count 0..FIFO_DEPTH.
- Drain: update_en = (count≠0) && !update_stall, combinational from state and update_stall; pc_update/target_addr_update always show the head entry (0 when empty). Pop on the edge where update_en=1.
- Full: push with no simultaneous pop → new entry discarded, cnt_dropped +1. Push and pop in the same cycle while full → both happen, nothing dropped, count unchanged.
- Empty: no pop, update_en=0; push into empty is not bypassed.
- Counters: cnt_branches +1 per accept; cnt_mispredicts +1 per mispredict; all saturate at all-ones.

## Timing
- Reset (asynchronous, any time): redirect_valid=0, redirect_pc=0, flush=0, queue emptied (pending updates discarded), update_en=0, pc_update=0, target_addr_update=0, all counters 0. Outputs hold these values until the first edge after rst deasserts.
- Resolve in cycle t → redirect_valid/flush/redirect_pc valid in cycle t+1 only (one-cycle pulse; redirect_pc holds its value afterward).
- Push at end of t → update_en earliest in t+1 → BTB write at end of t+1. Minimum resolve-to-BTB-write latency 2 edges.
- Back-to-back mispredicts: second is in the shadow cycle and ignored; a resolution in t+2 is accepted normally.
- Counters update on the edge ending the accepting cycle.

## Test plan
- Reset mid-drain: queue 3 entries, update_stall=1, assert rst → all outputs 0 immediately, after release update_en stays 0 with stall=0.
- Cold miss: ex_pc=0x100, taken=1, ex_target=0x200, pred_hit=0 → t+1 redirect_valid=1, redirect_pc=0x200; t+1 update_en=1, pc_update=0x100, target_addr_update=0x200; cnt_mispredicts=1.
- False taken: ex_pc=0xFFFFFFFC, pred_hit=1, taken=0 → redirect_pc=0x00000000 (wrap), no update_en, cnt_branches=1.
- Correct prediction: pred_hit=1, taken=1, both targets 0x400 → no redirect, no push, cnt_mispredicts unchanged.
- Shadow: mispredict at t, another mispredicting ex_valid at t+1 → single redirect pulse, one push, cnt_branches=1.
- Full queue, FIFO_DEPTH=4, update_stall=1: five target-changing pushes → count=4, cnt_dropped=1; release stall → four writes in consecutive cycles in push order; with stall=0 and full, push+pop same cycle → cnt_dropped unchanged.
